imu_spi_responder: RTL and testbench

IMU_SPI_RESPONDER -- requirements
Module: imu_spi_responder

---
 rtl/imu_spi_pkg.sv | 21 ++
 rtl/spi_sync_edge.sv | 48 ++++
 rtl/imu_spi_responder.sv | 214 +++++++++++++++++++++
 tb/tb_imu_spi_responder.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/imu_spi_pkg.sv
// imu_spi_pkg
//   Shared definitions for the IMU SPI responder: FSM state encoding, the
//   position of the read flag in the command byte, and the default register
//   count and identification byte.
package imu_spi_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMD  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

  // Command byte: bit 7 flags a read, bits [3:0] carry the start index
  localparam int READ_BIT = 7;

  localparam int         NUM_REGS_DEFAULT = 9;
  localparam logic [7:0] IDENT_DEFAULT    = 8'h5A;

  localparam int WORD_BITS = 16;

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge
//   Multi-flop synchronizer for one asynchronous SPI line, followed by
//   edge detection in the system clock domain.
// Ports:
//   clock    - system clock
//   reset_n  - asynchronous active-low reset
//   din      - raw asynchronous input
//   level    - synchronized level
//   rise     - one-cycle pulse on a synchronized 0->1 transition
//   fall     - one-cycle pulse on a synchronized 1->0 transition
module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain_q;
  logic [STAGES-1:0] chain_d;
  logic              prev_q;

  always_comb begin
    chain_d[0] = din;
    for (int i = 1; i < STAGES; i++) begin
      chain_d[i] = chain_q[i-1];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      chain_q <= {STAGES{RESET_VAL}};
      prev_q  <= RESET_VAL;
    end else begin
      chain_q <= chain_d;
      prev_q  <= chain_q[STAGES-1];
    end
  end

  assign level = chain_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/imu_spi_responder.sv
// imu_spi_responder
//   SPI mode-0 slave serving NUM_REGS 16-bit telemetry words. A frame starts
//   on ss fall (telemetry snapshotted into a shadow bank), the first byte is
//   a command while IDENT is shifted out, then words stream MSB first from the
//   requested index with wrap-around until ss rises.
// Ports:
//   clock, reset_n  - system clock, asynchronous active-low reset
//   regs_in         - parallel telemetry, word k at [16k+15:16k]
//   sck, ss, mosi   - SPI from master (ss active low)
//   miso            - SPI data to master
//   cmd_valid       - pulse when a read command is accepted
//   cmd_index       - start index of the last accepted command
//   frame_done      - pulse at the end of a frame that reached DATA
//   cmd_error       - pulse when a command is rejected
//   busy            - high while a frame is in progress
module imu_spi_responder
  import imu_spi_pkg::*;
#(
  parameter int         NUM_REGS    = NUM_REGS_DEFAULT,
  parameter logic [7:0] IDENT       = IDENT_DEFAULT,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [WORD_BITS*NUM_REGS-1:0] regs_in,
  input  logic                         sck,
  input  logic                         ss,
  input  logic                         mosi,
  output logic                         miso,
  output logic                         cmd_valid,
  output logic [3:0]                   cmd_index,
  output logic                         frame_done,
  output logic                         cmd_error,
  output logic                         busy
);

  // ---------------- synchronizers ----------------
  logic sck_level_unused, sck_rise, sck_fall;
  logic ss_level, ss_rise, ss_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
    .clock(clock), .reset_n(reset_n), .din(sck),
    .level(sck_level_unused), .rise(sck_rise), .fall(sck_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ss_sync (
    .clock(clock), .reset_n(reset_n), .din(ss),
    .level(ss_level), .rise(ss_rise), .fall(ss_fall)
  );

  // mosi uses the same depth as sck so a sampled bit lines up with its edge
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   mosi_s;

  always_comb begin
    mosi_sync_d[0] = mosi;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      mosi_sync_d[i] = mosi_sync_q[i-1];
    end
  end
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // ---------------- arming after reset ----------------
  // The ss synchronizer resets to "high", so if ss is really low when reset
  // releases it produces an artificial fall. Edges are ignored until the
  // chain has flushed, and frames are only accepted once ss has been seen
  // high, so a frame can never be entered while ss is already low.
  localparam logic [3:0] FLUSH_CYCLES = 4'(SYNC_STAGES + 1);

  logic [3:0] flush_q, flush_d;
  logic       armed_q, armed_d;
  logic       settled;

  assign settled = (flush_q == FLUSH_CYCLES);

  always_comb begin
    flush_d = settled ? flush_q : flush_q + 4'd1;
    armed_d = armed_q | (settled & ss_level);
  end

  // ---------------- frame FSM and datapath ----------------
  logic [1:0]                      state_q, state_d;
  logic [WORD_BITS*NUM_REGS-1:0]   shadow_q, shadow_d;
  logic [WORD_BITS-1:0]            tx_q, tx_d;
  logic [6:0]                      rx_q, rx_d;
  logic [3:0]                      bit_cnt_q, bit_cnt_d;
  logic [3:0]                      word_idx_q, word_idx_d;
  logic [3:0]                      cmd_index_q, cmd_index_d;
  logic                            cmd_valid_q, cmd_valid_d;
  logic                            cmd_error_q, cmd_error_d;
  logic                            frame_done_q, frame_done_d;
  logic                            miso_q, miso_d;
  logic                            busy_q, busy_d;

  logic [7:0]           cmd_byte;
  logic [3:0]           cmd_idx;
  logic [2:0]           cmd_rsvd_unused;
  logic [WORD_BITS-1:0] cur_word;

  // Complete command byte as of the 8th sck rise (last bit still on mosi_s)
  assign cmd_byte        = {rx_q, mosi_s};
  assign cmd_idx         = cmd_byte[3:0];
  assign cmd_rsvd_unused = cmd_byte[6:4];
  assign cur_word        = shadow_q[32'(word_idx_q)*WORD_BITS +: WORD_BITS];

  always_comb begin
    state_d      = state_q;
    shadow_d     = shadow_q;
    tx_d         = tx_q;
    rx_d         = rx_q;
    bit_cnt_d    = bit_cnt_q;
    word_idx_d   = word_idx_q;
    cmd_index_d  = cmd_index_q;
    cmd_valid_d  = 1'b0;
    cmd_error_d  = 1'b0;
    frame_done_d = 1'b0;

    if (ss_rise) begin
      // End of frame from any state; partial bytes/words are simply dropped
      frame_done_d = (state_q == ST_DATA);
      state_d      = ST_IDLE;
      bit_cnt_d    = 4'd0;
      tx_d         = '0;
      rx_d         = '0;
    end else if (state_q == ST_IDLE) begin
      if (ss_fall && armed_q) begin
        state_d   = ST_CMD;
        shadow_d  = regs_in;
        tx_d      = {IDENT, 8'h00};
        rx_d      = '0;
        bit_cnt_d = 4'd0;
      end
    end else if (sck_rise) begin
      if (state_q == ST_CMD) begin
        rx_d      = {rx_q[5:0], mosi_s};
        bit_cnt_d = bit_cnt_q + 4'd1;
        if (bit_cnt_q == 4'd7) begin
          bit_cnt_d = 4'd0;
          if (cmd_byte[READ_BIT] && (32'(cmd_idx) < NUM_REGS)) begin
            state_d     = ST_DATA;
            cmd_valid_d = 1'b1;
            cmd_index_d = cmd_idx;
            word_idx_d  = cmd_idx;
          end else begin
            state_d     = ST_ERR;
            cmd_error_d = 1'b1;
          end
        end
      end else if (state_q == ST_DATA) begin
        // 4-bit counter wraps 15 -> 0 at the end of each word
        bit_cnt_d = bit_cnt_q + 4'd1;
        if (bit_cnt_q == 4'd15) begin
          word_idx_d = (word_idx_q == 4'(NUM_REGS - 1)) ? 4'd0 : word_idx_q + 4'd1;
        end
      end
    end else if (sck_fall) begin
      // A fall with the counter at 0 in DATA is the one that precedes the
      // first bit of a word (the 8th command fall, or the 16th of the
      // previous word): load the next word so its MSB is ready for the rise.
      if (state_q == ST_DATA && bit_cnt_q == 4'd0) begin
        tx_d = cur_word;
      end else if (state_q == ST_CMD || state_q == ST_DATA) begin
        tx_d = {tx_q[WORD_BITS-2:0], 1'b0};
      end
    end

    miso_d = ((state_d == ST_CMD) || (state_d == ST_DATA)) & tx_d[WORD_BITS-1];
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mosi_sync_q  <= '0;
      flush_q      <= 4'd0;
      armed_q      <= 1'b0;
      state_q      <= ST_IDLE;
      shadow_q     <= '0;
      tx_q         <= '0;
      rx_q         <= '0;
      bit_cnt_q    <= 4'd0;
      word_idx_q   <= 4'd0;
      cmd_index_q  <= 4'd0;
      cmd_valid_q  <= 1'b0;
      cmd_error_q  <= 1'b0;
      frame_done_q <= 1'b0;
      miso_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      mosi_sync_q  <= mosi_sync_d;
      flush_q      <= flush_d;
      armed_q      <= armed_d;
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      tx_q         <= tx_d;
      rx_q         <= rx_d;
      bit_cnt_q    <= bit_cnt_d;
      word_idx_q   <= word_idx_d;
      cmd_index_q  <= cmd_index_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_error_q  <= cmd_error_d;
      frame_done_q <= frame_done_d;
      miso_q       <= miso_d;
      busy_q       <= busy_d;
    end
  end

  assign miso       = miso_q;
  assign cmd_valid  = cmd_valid_q;
  assign cmd_index  = cmd_index_q;
  assign frame_done = frame_done_q;
  assign cmd_error  = cmd_error_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_imu_spi_responder.sv
// tb_imu_spi_responder
//   Directed bench for imu_spi_responder: an SPI mode-0 master drives frames
//   at clock/10 and compares received bits and status pulses against
//   hand-computed values.
module tb_imu_spi_responder;

  localparam int NREGS = 9;
  localparam int HALF  = 5;   // sck half period in system clocks

  logic                 clock;
  logic                 reset_n;
  logic [16*NREGS-1:0]  regs_in;
  logic                 sck, ss, mosi;
  logic                 miso;
  logic                 cmd_valid;
  logic [3:0]           cmd_index;
  logic                 frame_done;
  logic                 cmd_error;
  logic                 busy;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_cv   = 0;
  int n_fd   = 0;
  int n_ce   = 0;

  imu_spi_responder #(.NUM_REGS(NREGS), .IDENT(8'h5A), .SYNC_STAGES(2)) dut (
    .clock(clock), .reset_n(reset_n), .regs_in(regs_in),
    .sck(sck), .ss(ss), .mosi(mosi), .miso(miso),
    .cmd_valid(cmd_valid), .cmd_index(cmd_index), .frame_done(frame_done),
    .cmd_error(cmd_error), .busy(busy)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  // Pulse counters, only written here
  always @(negedge clock) begin
    if (cmd_valid)  n_cv <= n_cv + 1;
    if (frame_done) n_fd <= n_fd + 1;
    if (cmd_error)  n_ce <= n_ce + 1;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_regs(input logic [15:0] base);
    for (int k = 0; k < NREGS; k++) begin
      regs_in[16*k +: 16] = 16'(base * 16'(k + 1));
    end
  endtask

  // Mode 0 master: set mosi, rise (sample miso), fall
  task automatic xfer(input logic [15:0] dout, input int nbits, output logic [15:0] din);
    din = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = dout[nbits-1-i];
      repeat (HALF) @(negedge clock);
      din = {din[14:0], miso};
      sck = 1'b1;
      repeat (HALF) @(negedge clock);
      sck = 1'b0;
    end
    mosi = 1'b0;
  endtask

  task automatic start_frame();
    ss = 1'b0;
    repeat (8) @(negedge clock);
  endtask

  task automatic end_frame();
    repeat (HALF) @(negedge clock);
    ss = 1'b1;
    repeat (8) @(negedge clock);
  endtask

  // Command 0x80 with default telemetry, two words
  task automatic basic_read(input string tag);
    logic [15:0] rd;
    int cv0, fd0;
    cv0 = n_cv; fd0 = n_fd;
    start_frame();
    check({tag, " busy_in_frame"}, {15'd0, busy}, 16'd1);
    xfer(16'h0080, 8, rd);
    check({tag, " ident"}, rd, 16'h005A);
    repeat (2) @(negedge clock);
    check({tag, " cmd_valid_cnt"}, 16'(n_cv - cv0), 16'd1);
    check({tag, " cmd_index"}, {12'd0, cmd_index}, 16'd0);
    xfer(16'h0000, 16, rd);
    check({tag, " word0"}, rd, 16'h1111);
    xfer(16'h0000, 16, rd);
    check({tag, " word1"}, rd, 16'h2222);
    end_frame();
    check({tag, " frame_done_cnt"}, 16'(n_fd - fd0), 16'd1);
    check({tag, " busy_after"}, {15'd0, busy}, 16'd0);
  endtask

  task automatic bad_cmd(input string tag, input logic [7:0] cmd);
    logic [15:0] rd;
    int ce0, fd0;
    ce0 = n_ce; fd0 = n_fd;
    start_frame();
    xfer({8'h00, cmd}, 8, rd);
    check({tag, " ident"}, rd, 16'h005A);
    xfer(16'h0000, 16, rd);
    check({tag, " miso_zero"}, rd, 16'h0000);
    check({tag, " cmd_error_cnt"}, 16'(n_ce - ce0), 16'd1);
    end_frame();
    check({tag, " no_frame_done"}, 16'(n_fd - fd0), 16'd0);
    check({tag, " cmd_index_kept"}, {12'd0, cmd_index}, 16'd8);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rd;
    int cv0, fd0;

    reset_n = 1'b0; ss = 1'b1; sck = 1'b0; mosi = 1'b0;
    set_regs(16'h1111);
    repeat (3) @(negedge clock);

    // Reset state
    check("rst miso",       {15'd0, miso},       16'd0);
    check("rst cmd_valid",  {15'd0, cmd_valid},  16'd0);
    check("rst cmd_index",  {12'd0, cmd_index},  16'd0);
    check("rst frame_done", {15'd0, frame_done}, 16'd0);
    check("rst cmd_error",  {15'd0, cmd_error},  16'd0);
    check("rst busy",       {15'd0, busy},       16'd0);
    reset_n = 1'b1;
    repeat (10) @(negedge clock);
    check("idle busy", {15'd0, busy}, 16'd0);

    // Basic read from index 0
    basic_read("t1");

    // Start at last register, read three words with wrap
    start_frame();
    xfer(16'h0088, 8, rd);
    check("t2 ident", rd, 16'h005A);
    repeat (2) @(negedge clock);
    check("t2 cmd_index", {12'd0, cmd_index}, 16'd8);
    xfer(16'h0000, 16, rd); check("t2 word0", rd, 16'h9999);
    xfer(16'h0000, 16, rd); check("t2 word1", rd, 16'h1111);
    xfer(16'h0000, 16, rd); check("t2 word2", rd, 16'h2222);
    end_frame();

    // Rejected commands: write flag, and out-of-range index
    bad_cmd("t3a", 8'h09);
    bad_cmd("t3b", 8'h8C);

    // Telemetry change after the frame started is not served
    start_frame();
    set_regs(16'h0AAA);
    xfer(16'h0080, 8, rd);
    xfer(16'h0000, 16, rd); check("t4 word0", rd, 16'h1111);
    xfer(16'h0000, 16, rd); check("t4 word1", rd, 16'h2222);
    end_frame();
    set_regs(16'h1111);

    // Abort after 5 data bits, then a fresh frame from index 1
    fd0 = n_fd;
    start_frame();
    xfer(16'h0080, 8, rd);
    xfer(16'h0000, 5, rd);
    check("t5 partial", rd, 16'h0002);
    end_frame();
    check("t5 frame_done_cnt", 16'(n_fd - fd0), 16'd1);
    start_frame();
    xfer(16'h0081, 8, rd);
    check("t5 ident", rd, 16'h005A);
    xfer(16'h0000, 16, rd);
    check("t5 word0", rd, 16'h2222);
    check("t5 cmd_index", {12'd0, cmd_index}, 16'd1);
    end_frame();

    // Reset in the middle of DATA
    start_frame();
    xfer(16'h0083, 8, rd);
    xfer(16'h0000, 3, rd);
    check("t6 partial", rd, 16'h0002);
    @(negedge clock);
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    check("t6 rst miso",      {15'd0, miso},      16'd0);
    check("t6 rst busy",      {15'd0, busy},      16'd0);
    check("t6 rst cmd_index", {12'd0, cmd_index}, 16'd0);
    reset_n = 1'b1;
    cv0 = n_cv; fd0 = n_fd;
    repeat (20) @(negedge clock);
    check("t6 no_frame_busy", {15'd0, busy}, 16'd0);
    xfer(16'h0080, 8, rd);
    check("t6 no_frame_miso", rd, 16'h0000);
    check("t6 no_cmd_valid", 16'(n_cv - cv0), 16'd0);
    end_frame();
    check("t6 no_frame_done", 16'(n_fd - fd0), 16'd0);
    basic_read("t6b");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
